effect_sample_source: RTL
=========================

Name: effect_sample_source

Overview:
- Producer end of the effects-module sample handshake (`ready` / `incoming_sample` in, `done` / `modified_sample` out).
- Buffers 12-bit signed samples from an upstream writer (drum-sample playback, codec input) in a small FIFO.
- Issues exactly one sample with a one-cycle `ready` strobe every PERIOD clocks.
- Waits for the effect's `done`, captures the processed result, and reports underrun, overflow and missing-done (timeout) events.

Parameters:
- WIDTH, 12: sample width in bits (two's complement).
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 = 16 entries.
- PERIOD, 64: clocks between successive `ready` strobes.
- TIMEOUT, 48: max clocks from `ready` to `done`. Must satisfy TIMEOUT < PERIOD-2; violating this is a compile-time error.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  push `wr_sample` into the FIFO this cycle.
- wr_sample  in  WIDTH  signed sample to buffer.
- fifo_full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- fifo_count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  one-cycle pulse: write dropped because FIFO full.
- ready  out  1  one-cycle strobe to the effect module.
- sample_out  out  WIDTH  sample presented to the effect module.
- done  in  1  effect module finished the current sample.
- modified_sample  in  WIDTH  effect result, valid when `done` = 1.
- out_valid  out  1  one-cycle pulse: `out_sample` updated.
- out_sample  out  WIDTH  last captured effect result.
- underrun  out  1  one-cycle pulse: tick found FIFO empty.
- timeout_err  out  1  one-cycle pulse: `done` not seen within TIMEOUT.

Behaviour:

Reset:
- All outputs are 0.
- FIFO is emptied (pointers 0, `fifo_count` 0).
- Period counter is 0; state is IDLE.
- Reset asserted mid-transaction aborts it: no `out_valid` and no `timeout_err` is produced for the aborted sample.

Period counter:
- Free-running 0..PERIOD-1, wraps to 0.
- `tick` = (count == PERIOD-1).
- The first tick after reset falls on the PERIOD-th clock edge after reset deasserts.

State IDLE, on tick:
- FIFO non-empty: pop the head into `sample_out`; `ready` = 1 on the next cycle only; go to WAIT_DONE.
- FIFO empty: `sample_out` <= 0; `ready` still pulses, so the audio rate is preserved; `underrun` pulses in the same cycle as `ready`; go to WAIT_DONE.
- `sample_out` holds its value until the next issue.

State WAIT_DONE:
- The timeout counter starts at 0 in the `ready` cycle and increments each cycle.
- `done` = 1 in a cycle after the `ready` cycle:
  - `out_sample` <= `modified_sample`.
  - `out_valid` = 1 on the following cycle.
  - Return to IDLE.
- Timeout counter reaches TIMEOUT before `done`:
  - `timeout_err` pulses for one cycle.
  - `out_sample` is unchanged.
  - Return to IDLE.

Ignored `done`:
- `done` in the same cycle as `ready` is ignored; minimum effect latency is 1.
- `done` while in IDLE is ignored.
- `done` held high for several cycles is consumed only once.

FIFO writes:
- `wr_en` when not full: store the sample; `fifo_count` increments.
- `wr_en` when full and no pop this cycle: sample dropped; `overflow` pulses next cycle.
- `wr_en` and pop in the same cycle: both succeed, including when full; count unchanged.
- Pointers wrap modulo 2^DEPTH_LOG2.
- `fifo_full` and `fifo_count` are registered and reflect state after the edge.

Arithmetic:
- No arithmetic on sample values; samples pass through bit-exact.
- Counters are unsigned.

Decomposition:
- Shared package `effects_pkg`:
  - SAMPLE_W = 12
  - `sample_t` (signed [SAMPLE_W-1:0])
  - `src_state_t` enum {IDLE, WAIT_DONE}
  - default PERIOD = 64
- One sub-module: `sample_fifo` (parameters WIDTH and DEPTH_LOG2). It is a synchronous single-clock FIFO with push, pop, full, empty and count, and defines the same-cycle push/pop semantics above.
- The top level holds the period counter, FSM, timeout counter and output registers.

Test Plan:
1. Reset, then write 100, -200, 2047 on three consecutive cycles and tie `done` to `ready` delayed 5 clocks with `modified_sample` = `sample_out` + 1 → `ready` at clocks 64, 128 and 192 after reset release; `sample_out` = 100, -200, 2047; `out_sample` = 101, -199, -2048 (wrap), each `out_valid` 6 cycles after its `ready`.
2. FIFO empty at a tick → `ready` still pulses; `sample_out` = 0; `underrun` = 1 in the `ready` cycle; `fifo_count` stays 0.
3. Write 17 samples with no pops → `fifo_full` = 1 after the 16th; 17th dropped with one `overflow` pulse; `fifo_count` = 16; next pops return samples 1..16 in order.
4. `done` never asserted after `ready` → `timeout_err` is a single pulse 48 cycles after `ready`; `out_sample` unchanged; next tick issues the next FIFO entry normally.
5. `done` asserted in the `ready` cycle and held for 3 cycles → the `ready`-cycle `done` is ignored; capture happens on the second cycle; exactly one `out_valid` pulse.
6. Assert `reset` during WAIT_DONE 10 cycles after `ready` → all outputs return to 0; FIFO emptied; no `out_valid` or `timeout_err`; next `ready` 64 clocks after reset release.

Source files
------------

// File: rtl/effects_pkg.sv
// Shared types and defaults for the effects-module sample handshake.
package effects_pkg;

    localparam int SAMPLE_W       = 12;
    localparam int DEFAULT_PERIOD = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } src_state_t;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/effect_sample_source_if.sv
// Sample handshake between the producer (master) and an effect module (slave).
interface effect_sample_source_if
    import effects_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
);

    logic                    ready;
    logic signed [WIDTH-1:0] sample_out;
    logic                    done;
    logic signed [WIDTH-1:0] modified_sample;

    modport master (
        output ready,
        output sample_out,
        input  done,
        input  modified_sample
    );

    modport slave (
        input  ready,
        input  sample_out,
        output done,
        output modified_sample
    );

endinterface

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO. A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and flagged on `drop`.
module sample_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic signed [WIDTH-1:0] push_data,
    input  logic                    pop,
    output logic signed [WIDTH-1:0] pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the head slot this edge, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/effect_sample_source.sv
// Producer end of the effect handshake: buffers incoming samples, issues one
// per PERIOD clocks with a ready strobe, and captures the effect's result.
module effect_sample_source
    import effects_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_W,
    parameter int DEPTH_LOG2 = 4,
    parameter int PERIOD     = DEFAULT_PERIOD,
    parameter int TIMEOUT    = 48
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_sample,
    output logic                    fifo_full,
    output logic [DEPTH_LOG2:0]     fifo_count,
    output logic                    overflow,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_sample,
    output logic                    underrun,
    output logic                    timeout_err,
    effect_sample_source_if.master  fx
);

    localparam int CNT_W = cnt_w(PERIOD);
    localparam int TO_W  = cnt_w(TIMEOUT + 1);

    // The transaction must end before the next tick can issue a sample.
    if (!(TIMEOUT < PERIOD - 2)) begin : g_bad_timeout
        $error("effect_sample_source: TIMEOUT must be less than PERIOD-2");
    end

    src_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    ready_q, ready_d;
    logic signed [WIDTH-1:0] sample_out_q, sample_out_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_sample_q, out_sample_d;
    logic                    underrun_q, underrun_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    overflow_q, overflow_d;

    logic                    tick;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic                    fifo_drop;
    logic signed [WIDTH-1:0] fifo_head;

    sample_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_sample),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    assign tick     = (cnt_q == CNT_W'(PERIOD - 1));
    assign fifo_pop = (state_q == IDLE) && tick && !fifo_empty;

    assign fx.ready      = ready_q;
    assign fx.sample_out = sample_out_q;
    assign out_valid     = out_valid_q;
    assign out_sample    = out_sample_q;
    assign underrun      = underrun_q;
    assign timeout_err   = timeout_err_q;
    assign overflow      = overflow_q;

    // Period counter, issue/wait FSM, timeout counter and output pulses.
    always_comb begin
        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        ready_d       = 1'b0;
        sample_out_d  = sample_out_q;
        underrun_d    = 1'b0;
        out_valid_d   = 1'b0;
        out_sample_d  = out_sample_q;
        timeout_err_d = 1'b0;
        overflow_d    = fifo_drop;

        case (state_q)
            IDLE: begin
                // Ready pulses even on an empty FIFO to keep the audio rate.
                if (tick) begin
                    ready_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                    if (fifo_empty) begin
                        sample_out_d = '0;
                        underrun_d   = 1'b1;
                    end else begin
                        sample_out_d = fifo_head;
                    end
                end
            end
            WAIT_DONE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // done in the ready cycle itself is not a response.
                if (fx.done && !ready_q) begin
                    out_sample_d = fx.modified_sample;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            ready_q       <= 1'b0;
            sample_out_q  <= '0;
            out_valid_q   <= 1'b0;
            out_sample_q  <= '0;
            underrun_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            ready_q       <= ready_d;
            sample_out_q  <= sample_out_d;
            out_valid_q   <= out_valid_d;
            out_sample_q  <= out_sample_d;
            underrun_q    <= underrun_d;
            timeout_err_q <= timeout_err_d;
            overflow_q    <= overflow_d;
        end
    end

endmodule
